// File: rtl/val2_seq_shifter_pkg.sv
// Shared definitions for the sequential operand-2 shifter: datapath widths,
// shift type codes and FSM state encodings.
package val2_seq_shifter_pkg;

    localparam int WORD_WIDTH            = 32;
    localparam int SHIFTER_OPERAND_WIDTH = 12;
    localparam int AMOUNT_WIDTH          = 5;

    typedef enum logic [1:0] {
        LSL_SHIFT = 2'b00,
        LSR_SHIFT = 2'b01,
        ASR_SHIFT = 2'b10,
        ROR_SHIFT = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        VAL2_SEQ_IDLE  = 2'b00,
        VAL2_SEQ_SHIFT = 2'b01,
        VAL2_SEQ_DONE  = 2'b10
    } val2_seq_state_e;

    // Positions to shift this cycle: never more than the per-cycle step.
    function automatic logic [AMOUNT_WIDTH-1:0] step_amount(
        input logic [AMOUNT_WIDTH-1:0] remaining,
        input logic [AMOUNT_WIDTH-1:0] step
    );
        return (remaining > step) ? step : remaining;
    endfunction

endpackage

// File: rtl/val2_shift_step.sv
// Combinational single-step shifter: applies LSL/LSR/ASR/ROR by k positions,
// where k is bounded by the caller to the per-cycle step size.
module val2_shift_step
    import val2_seq_shifter_pkg::*;
(
    input  logic [WORD_WIDTH-1:0]   data,
    input  logic [1:0]              shift_type,
    input  logic [AMOUNT_WIDTH-1:0] k,
    output logic [WORD_WIDTH-1:0]   result
);

    logic [2*WORD_WIDTH-1:0] rotated;

    // Rotation is taken from the low half of the doubled word, so k=0 is identity.
    always_comb begin
        rotated = {data, data} >> k;
        result  = data;
        case (shift_type)
            LSL_SHIFT: result = data << k;
            LSR_SHIFT: result = data >> k;
            ASR_SHIFT: result = $unsigned($signed(data) >>> k);
            ROR_SHIFT: result = rotated[WORD_WIDTH-1:0];
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/val2_seq_shifter.sv
// Multi-cycle operand-2 generator: decodes the request at accept, then shifts
// at most STEP positions per cycle and holds the result until it is taken.
module val2_seq_shifter
    import val2_seq_shifter_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            val_Rm,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand,
    input  logic                             immediate,
    input  logic                             is_mem_cmd,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            val2_out,
    output logic                             busy
);

    localparam logic [AMOUNT_WIDTH-1:0] STEP_K = AMOUNT_WIDTH'(STEP);

    val2_seq_state_e           state;
    logic [WORD_WIDTH-1:0]     work;
    logic [1:0]                work_type;
    logic [AMOUNT_WIDTH-1:0]   remaining;

    logic [WORD_WIDTH-1:0]     dec_work;
    logic [1:0]                dec_type;
    logic [AMOUNT_WIDTH-1:0]   dec_amount;
    logic [AMOUNT_WIDTH-1:0]   step_k;
    logic [WORD_WIDTH-1:0]     step_result;

    assign in_ready  = (state == VAL2_SEQ_IDLE) && !rst && !flush;
    assign out_valid = (state == VAL2_SEQ_DONE);
    assign busy      = (state != VAL2_SEQ_IDLE);

    // Zero-amount cases (memory offset, unsupported register shift) carry
    // their final result in dec_work so the accept path is uniform.
    always_comb begin
        dec_work   = '0;
        dec_type   = LSL_SHIFT;
        dec_amount = '0;
        if (is_mem_cmd) begin
            dec_work = {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){shift_operand[11]}}, shift_operand};
        end else if (immediate) begin
            dec_work   = {{(WORD_WIDTH-8){1'b0}}, shift_operand[7:0]};
            dec_type   = ROR_SHIFT;
            dec_amount = {shift_operand[11:8], 1'b0};
        end else if (!shift_operand[4]) begin
            dec_work   = val_Rm;
            dec_type   = shift_operand[6:5];
            dec_amount = shift_operand[11:7];
        end
    end

    assign step_k = step_amount(remaining, STEP_K);

    val2_shift_step u_step (
        .data       (work),
        .shift_type (work_type),
        .k          (step_k),
        .result     (step_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= VAL2_SEQ_IDLE;
            val2_out  <= '0;
            remaining <= '0;
            work      <= '0;
            work_type <= LSL_SHIFT;
        end else if (flush) begin
            state     <= VAL2_SEQ_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                VAL2_SEQ_IDLE: begin
                    if (in_valid) begin
                        if (dec_amount == '0) begin
                            val2_out <= dec_work;
                            state    <= VAL2_SEQ_DONE;
                        end else begin
                            work      <= dec_work;
                            work_type <= dec_type;
                            remaining <= dec_amount;
                            state     <= VAL2_SEQ_SHIFT;
                        end
                    end
                end
                VAL2_SEQ_SHIFT: begin
                    work      <= step_result;
                    remaining <= remaining - step_k;
                    if (remaining == step_k) begin
                        val2_out <= step_result;
                        state    <= VAL2_SEQ_DONE;
                    end
                end
                VAL2_SEQ_DONE: begin
                    if (out_ready) begin
                        state <= VAL2_SEQ_IDLE;
                    end
                end
                default: state <= VAL2_SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_val2_seq_shifter.sv
// Directed testbench for val2_seq_shifter with hand-computed results and
// latencies, covering backpressure, flush and reset aborts.
module tb_val2_seq_shifter;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val_Rm;
    logic [11:0] shift_operand;
    logic        immediate;
    logic        is_mem_cmd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val2_out;
    logic        busy;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] lastResult  = 32'h0;

    always #5 clk = ~clk;

    val2_seq_shifter #(.STEP(STEP)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .val_Rm        (val_Rm),
        .shift_operand (shift_operand),
        .immediate     (immediate),
        .is_mem_cmd    (is_mem_cmd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val2_out      (val2_out),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, then scramble the
    // inputs to show they were captured at accept.
    task automatic applyStimulus(input logic [31:0] rm, input logic [11:0] so,
                                 input logic imm, input logic mem);
        int budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        val_Rm        = rm;
        shift_operand = so;
        immediate     = imm;
        is_mem_cmd    = mem;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid      = 1'b0;
        val_Rm        = ~rm;
        shift_operand = ~so;
        immediate     = ~imm;
        is_mem_cmd    = ~mem;
    endtask

    task automatic runOp(input string tag, input logic [31:0] rm, input logic [11:0] so,
                         input logic imm, input logic mem, input logic [31:0] expected,
                         input int amount, input int holdCycles);
        int lat    = 1;
        int expLat = 1 + (amount + STEP - 1) / STEP;
        applyStimulus(rm, so, imm, mem);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_value"}, val2_out, expected);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput({tag, "_hold_value"}, val2_out, expected);
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_exit_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_exit_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_exit_busy"}, 32'(busy), 32'd0);
        lastResult = expected;
    endtask

    // Start ROR #31, abort it after nine shift cycles by flush or reset.
    task automatic abortOp(input string tag, input logic useRst);
        logic sawValid = 1'b0;
        applyStimulus(32'h0000_0001, 12'hFE0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            sawValid |= out_valid;
        end
        checkOutput({tag, "_busy_before"}, 32'(busy), 32'd1);
        if (useRst) rst = 1'b1;
        else        flush = 1'b1;
        #1;
        checkOutput({tag, "_in_ready_during"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        flush = 1'b0;
        if (useRst) lastResult = 32'h0;
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_value_after"}, val2_out, lastResult);
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            sawValid |= out_valid;
        end
        checkOutput({tag, "_valid_never"}, 32'(sawValid), 32'd0);
        checkOutput({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        val_Rm        = 32'h0;
        shift_operand = 12'h0;
        immediate     = 1'b0;
        is_mem_cmd    = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_val2", val2_out, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        runOp("imm_ror8",  32'h0,         12'h4FF, 1'b1, 1'b0, 32'hFF00_0000, 8,  0);
        runOp("mem_neg",   32'h1234_5678, 12'h800, 1'b1, 1'b1, 32'hFFFF_F800, 0,  0);
        runOp("mem_pos",   32'h1234_5678, 12'h7FF, 1'b0, 1'b1, 32'h0000_07FF, 0,  0);
        runOp("asr4",      32'h8000_0000, 12'h240, 1'b0, 1'b0, 32'hF800_0000, 4,  0);
        runOp("lsl3",      32'h0000_0011, 12'h180, 1'b0, 1'b0, 32'h0000_0088, 3,  0);
        runOp("reg_shift", 32'h1234_5678, 12'h010, 1'b0, 1'b0, 32'h0000_0000, 0,  0);
        runOp("ror31",     32'h0000_0001, 12'hFE0, 1'b0, 1'b0, 32'h0000_0002, 31, 0);
        runOp("lsr0",      32'hDEAD_BEEF, 12'h020, 1'b0, 1'b0, 32'hDEAD_BEEF, 0,  0);
        runOp("ror0",      32'hDEAD_BEEF, 12'h060, 1'b0, 1'b0, 32'hDEAD_BEEF, 0,  0);
        runOp("lsr8",      32'h8000_0000, 12'h420, 1'b0, 1'b0, 32'h0080_0000, 8,  0);
        runOp("asr31",     32'h8000_0000, 12'hFC0, 1'b0, 1'b0, 32'hFFFF_FFFF, 31, 0);
        runOp("imm_ror0",  32'h0,         12'h0AB, 1'b1, 1'b0, 32'h0000_00AB, 0,  0);
        runOp("imm_ror30", 32'h0,         12'hF01, 1'b1, 1'b0, 32'h0000_0004, 30, 0);
        runOp("backpress", 32'h0,         12'h4FF, 1'b1, 1'b0, 32'hFF00_0000, 8,  5);

        abortOp("flush_abort", 1'b0);
        abortOp("rst_abort", 1'b1);

        // Flush alongside a pending request in IDLE must block the accept.
        val_Rm        = 32'h0;
        shift_operand = 12'h7FF;
        immediate     = 1'b0;
        is_mem_cmd    = 1'b1;
        in_valid      = 1'b1;
        flush         = 1'b1;
        #1;
        checkOutput("flush_idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_idle_busy", 32'(busy), 32'd0);
        checkOutput("flush_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_idle_value", val2_out, lastResult);

        runOp("after_abort", 32'h0000_0011, 12'h180, 1'b0, 1'b0, 32'h0000_0088, 3, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/val2_seq_shifter.md
Name: val2_seq_shifter

Overview:
- Multi-cycle, area-reduced replacement for the single-cycle operand-2 generator in the EXE stage.
- Accepts one operand-2 request through a valid/ready handshake.
- Applies the immediate rotate or the register LSL/LSR/ASR/ROR as at most STEP bit positions per cycle, then holds the result until the consumer accepts it.
- The FSM here sequences a narrow single-step shift datapath; the hazard/stall unit uses in_ready/out_valid to freeze the pipe.

Parameters:
WORD_WIDTH, 32, datapath width (from defines.v)
SHIFTER_OPERAND_WIDTH, 12, shifter operand field width (from defines.v)
STEP, 1, maximum bit positions shifted per cycle; legal 1..31

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active high
in_valid  in  1  request present
in_ready  out  1  block can accept; = (state==IDLE) && !rst && !flush
val_Rm  in  WORD_WIDTH  register operand, sampled on accept
shift_operand  in  SHIFTER_OPERAND_WIDTH  instruction bits [11:0], sampled on accept
immediate  in  1  I bit, sampled on accept
is_mem_cmd  in  1  LDR/STR offset mode, sampled on accept
flush  in  1  synchronous abort of the in-flight request
out_valid  out  1  result valid; = (state==DONE)
out_ready  in  1  consumer takes result
val2_out  out  WORD_WIDTH  result register
busy  out  1  state != IDLE

Behaviour:
- Accept: in_valid && in_ready on a rising edge.
- Reset (rst=1 at an edge): state=IDLE, val2_out=0, remaining count=0; out_valid=0, busy=0. While rst is high, in_ready=0. Reset mid-operation discards the request.
- Decode at accept; operands are registered, so later input changes are ignored.
  - is_mem_cmd=1: result = sign-extend shift_operand[11] into 32 bits; amount=0.
  - immediate=1: work = {24'b0, shift_operand[7:0]}; type=ROR; amount = 2*shift_operand[11:8] (0..30).
  - otherwise, shift_operand[4]=0: work = val_Rm; type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amount = shift_operand[11:7] (0..31).
  - otherwise, shift_operand[4]=1 (register-specified shift, unsupported): result = 0; amount=0.
  - is_mem_cmd has priority over immediate.
- No ARM special-case encodings: LSR/ASR/ROR by 0 return val_Rm unchanged, and ROR #0 is not RRX.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on accept with amount=0, go to DONE and load the result. With amount>0, go to SHIFT and load work and remaining=amount.
  - SHIFT: each cycle, k = min(STEP, remaining). work = one_step(work, type, k); remaining -= k. When remaining reaches 0 in this cycle, go to DONE with val2_out = the new work.
  - DONE: val2_out and out_valid are held stable until out_ready=1; then go to IDLE.
  - No accept in the same cycle as the DONE->IDLE exit.
- Step arithmetic:
  - LSL/LSR: logical, zero fill.
  - ASR: fills with bit 31.
  - ROR: bits shifted out at bit 0 re-enter at bit 31.
  - Result is mod 2^WORD_WIDTH with no carry-out.
- Latency from accept edge to out_valid high = 1 + ceil(amount/STEP) cycles.
- Throughput: one request per (latency + 1) cycles at minimum.
- flush=1 at an edge, in any state: next state=IDLE and out_valid=0; val2_out keeps its last value.
  - flush has priority over out_ready and over a pending in_valid.
  - rst has priority over flush.
- busy and out_valid are never high in IDLE; in_ready is never high outside IDLE.

Decomposition:
- defines.v (shared) holds:
  - WORD_WIDTH and SHIFTER_OPERAND_WIDTH;
  - LSL_SHIFT/LSR_SHIFT/ASR_SHIFT/ROR_SHIFT codes;
  - new VAL2_SEQ_IDLE/SHIFT/DONE 2-bit state encodings.
- One combinational sub-module, val2_shift_step:
  - inputs: data, type, k (0..STEP);
  - output: data shifted or rotated by k;
  - instantiated once.
- The top level holds the FSM, the remaining counter and the operand registers.

Test Plan:
- Immediate rotate: immediate=1, shift_operand=12'h4FF -> val2_out=32'hFF000000. Latency 9 (STEP=1) / 3 (STEP=4).
- Memory offset: is_mem_cmd=1, immediate=1, shift_operand=12'h800 -> val2_out=32'hFFFFF800 after 1 cycle. Repeat with 12'h7FF -> 32'h000007FF.
- Register shifts:
  - ASR #4: val_Rm=32'h80000000, shift_operand=12'h240 -> 32'hF8000000, latency 5.
  - LSL #3: val_Rm=32'h00000011 -> 32'h00000088.
  - shift_operand[4]=1 -> 32'h0, latency 1.
- ROR #31: val_Rm=32'h00000001, shift_operand=12'hFE0 -> 32'h00000002. Latency 32 (STEP=1) / 9 (STEP=4).
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - val2_out, out_valid=1 and in_ready=0 stay stable.
  - Raise out_ready, then IDLE and in_ready=1 on the next cycle.
- Abort: with the ROR #31 request in flight, assert flush at SHIFT cycle 10 -> IDLE next cycle, out_valid never rises.
  - Repeat using rst -> val2_out=0.
  - Assert flush together with in_valid in IDLE -> not accepted.
